// File: rtl/order_limit_pkg.sv
// ----------------------------------------------------------------------------
// order_limit_pkg
// Shared definitions for the order limit tracker:
//   - default widths for client id, CPU amounts and exchange cancel amounts
//   - the two-state trading FSM encoding
// ----------------------------------------------------------------------------
package order_limit_pkg;

   localparam int DEF_CLIENT_W = 5;
   localparam int DEF_AMT_W    = 32;
   localparam int DEF_CXL_W    = 16;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/client_accum_table.sv
// ----------------------------------------------------------------------------
// client_accum_table
// Per-client open-order totals, 2**CLIENT_W entries of AMT_W bits.
//   clk, HRESETn     : clock, asynchronous active-low reset (clears all entries)
//   cxl_addr_i       : cancel-side client id, read combinationally on cxl_data_o
//   ord_addr_i       : order-side client id, read combinationally on ord_data_o
//   cxl_we_i/_wdata_i: cancel-side entry write
//   ord_we_i/_wdata_i: order-side entry write
// When both writes hit the same client the caller folds both deltas into
// ord_wdata_i, so the order-side write takes priority and carries the merged
// value.
// ----------------------------------------------------------------------------
module client_accum_table
   import order_limit_pkg::*;
#(
   parameter int CLIENT_W = DEF_CLIENT_W,
   parameter int AMT_W    = DEF_AMT_W
) (
   input  logic                clk,
   input  logic                HRESETn,
   input  logic [CLIENT_W-1:0] cxl_addr_i,
   output logic [AMT_W-1:0]    cxl_data_o,
   input  logic [CLIENT_W-1:0] ord_addr_i,
   output logic [AMT_W-1:0]    ord_data_o,
   input  logic                cxl_we_i,
   input  logic [AMT_W-1:0]    cxl_wdata_i,
   input  logic                ord_we_i,
   input  logic [AMT_W-1:0]    ord_wdata_i
);

   localparam int DEPTH = 1 << CLIENT_W;

   logic [AMT_W-1:0] entry_q [DEPTH];

   assign cxl_data_o = entry_q[cxl_addr_i];
   assign ord_data_o = entry_q[ord_addr_i];

   // NOTE: this table must read as zero right after reset, so it is built
   // from resettable flops rather than a RAM macro that cannot be cleared.
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         if (cxl_we_i) begin
            entry_q[cxl_addr_i] <= cxl_wdata_i;
         end
         // NOTE: non-blocking assignment order matters here -- the later
         // statement wins on an address collision, which is exactly the
         // merged write.
         if (ord_we_i) begin
            entry_q[ord_addr_i] <= ord_wdata_i;
         end
      end
   end

endmodule

// File: rtl/order_limit_tracker.sv
// ----------------------------------------------------------------------------
// order_limit_tracker
// Tracks open order volume against a global trading limit.
//   clk, HRESETn             : clock, asynchronous active-low reset
//   cpu_go, cpu_new_max      : CPU strobe; new_max=1 limit write, 0 order
//   cpu_client_id, cpu_amount: client and amount (or new limit)
//   exchange_go/_client_id/_amount : exchange cancel strobe
//   accumulated_orders       : open total over all clients
//   max_to_trade             : current limit
//   cancelled_orders         : saturating sum of applied cancels
//   order_ack / order_reject : one-cycle result pulses for orders
//   locked                   : FSM is in LOCKED
// Cancels are applied before the CPU command in the same cycle; the order
// check and the unlock check both see post-cancel totals.
// ----------------------------------------------------------------------------
module order_limit_tracker
   import order_limit_pkg::*;
#(
   parameter int CLIENT_W    = DEF_CLIENT_W,
   parameter int AMT_W       = DEF_AMT_W,
   parameter int CXL_W       = DEF_CXL_W,
   parameter bit LOCK_ON_HIT = 1'b1
) (
   input  logic                clk,
   input  logic                HRESETn,
   input  logic                cpu_go,
   input  logic                cpu_new_max,
   input  logic [CLIENT_W-1:0] cpu_client_id,
   input  logic [AMT_W-1:0]    cpu_amount,
   input  logic                exchange_go,
   input  logic [CLIENT_W-1:0] exchange_client_id,
   input  logic [CXL_W-1:0]    exchange_amount,
   output logic [AMT_W-1:0]    accumulated_orders,
   output logic [AMT_W-1:0]    max_to_trade,
   output logic [CXL_W-1:0]    cancelled_orders,
   output logic                order_ack,
   output logic                order_reject,
   output logic                locked
);

   state_e             state_q, state_d;
   logic [AMT_W-1:0]   acc_q, acc_d;
   logic [AMT_W-1:0]   max_q, max_d;
   logic [CXL_W-1:0]   cxl_q, cxl_d;
   logic               ack_q, ack_d;
   logic               rej_q, rej_d;

   logic [AMT_W-1:0]   cxl_entry, ord_entry;
   logic [AMT_W-1:0]   ex_amt_ext, applied, acc_post;
   logic [AMT_W-1:0]   cxl_wdata, ord_base, ord_wdata;
   logic [CXL_W:0]     cxl_sum;
   logic [AMT_W:0]     order_sum;
   logic               is_limit, is_order, fits, accept;

   client_accum_table #(
      .CLIENT_W (CLIENT_W),
      .AMT_W    (AMT_W)
   ) u_table (
      .clk         (clk),
      .HRESETn     (HRESETn),
      .cxl_addr_i  (exchange_client_id),
      .cxl_data_o  (cxl_entry),
      .ord_addr_i  (cpu_client_id),
      .ord_data_o  (ord_entry),
      .cxl_we_i    (exchange_go),
      .cxl_wdata_i (cxl_wdata),
      .ord_we_i    (accept),
      .ord_wdata_i (ord_wdata)
   );

   // NOTE: every signal gets a default before any branch, so no path leaves
   // a combinational output unassigned and no latch is inferred.
   always_comb begin
      is_limit   = cpu_go &  cpu_new_max;
      is_order   = cpu_go & ~cpu_new_max;

      // Cancel stage: never remove more than the client actually has open.
      ex_amt_ext = AMT_W'(exchange_amount);
      applied    = '0;
      if (exchange_go) begin
         applied = (ex_amt_ext < cxl_entry) ? ex_amt_ext : cxl_entry;
      end
      acc_post   = acc_q - applied;
      cxl_wdata  = cxl_entry - applied;

      // applied never exceeds exchange_amount, so its low CXL_W bits hold it.
      cxl_sum    = {1'b0, cxl_q} + {1'b0, applied[CXL_W-1:0]};
      cxl_d      = cxl_sum[CXL_W] ? '1 : cxl_sum[CXL_W-1:0];

      // Order stage, against post-cancel totals. The extra bit keeps a wrap
      // of acc+amount from sneaking under the limit.
      order_sum  = {1'b0, acc_post} + {1'b0, cpu_amount};
      fits       = (cpu_amount == '0) || (order_sum <= {1'b0, max_q});
      accept     = is_order && (state_q == ST_RUN) && fits;

      // Same client on both sides: fold the cancel into the order's base.
      ord_base   = (exchange_go && (exchange_client_id == cpu_client_id)) ?
                   cxl_wdata : ord_entry;
      ord_wdata  = ord_base + cpu_amount;

      acc_d      = accept ? (acc_post + cpu_amount) : acc_post;
      max_d      = is_limit ? cpu_amount : max_q;
      ack_d      = accept;
      rej_d      = is_order && !accept;

      state_d    = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (rej_d && LOCK_ON_HIT) state_d = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (is_limit && (cpu_amount > acc_post)) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_RUN;
         acc_q   <= '0;
         max_q   <= '0;
         cxl_q   <= '0;
         ack_q   <= 1'b0;
         rej_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         max_q   <= max_d;
         cxl_q   <= cxl_d;
         ack_q   <= ack_d;
         rej_q   <= rej_d;
      end
   end

   assign accumulated_orders = acc_q;
   assign max_to_trade       = max_q;
   assign cancelled_orders   = cxl_q;
   assign order_ack          = ack_q;
   assign order_reject       = rej_q;
   assign locked             = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_order_limit_tracker.sv
// ----------------------------------------------------------------------------
// tb_order_limit_tracker
// Scenario tasks drive strobes on the falling edge; a reference model
// computes the expected register state and pushes it to a scoreboard queue,
// which is popped and compared on the next falling edge.
// ----------------------------------------------------------------------------
module tb_order_limit_tracker;

   localparam int CLIENT_W = 5;
   localparam int AMT_W    = 32;
   localparam int CXL_W    = 16;
   localparam int NCLIENT  = 1 << CLIENT_W;

   logic                clk = 1'b0;
   logic                HRESETn;
   logic                cpu_go, cpu_new_max;
   logic [CLIENT_W-1:0] cpu_client_id;
   logic [AMT_W-1:0]    cpu_amount;
   logic                exchange_go;
   logic [CLIENT_W-1:0] exchange_client_id;
   logic [CXL_W-1:0]    exchange_amount;
   logic [AMT_W-1:0]    accumulated_orders, max_to_trade;
   logic [CXL_W-1:0]    cancelled_orders;
   logic                order_ack, order_reject, locked;

   always #5 clk = ~clk;

   order_limit_tracker #(
      .CLIENT_W    (CLIENT_W),
      .AMT_W       (AMT_W),
      .CXL_W       (CXL_W),
      .LOCK_ON_HIT (1'b1)
   ) dut (
      .clk                (clk),
      .HRESETn            (HRESETn),
      .cpu_go             (cpu_go),
      .cpu_new_max        (cpu_new_max),
      .cpu_client_id      (cpu_client_id),
      .cpu_amount         (cpu_amount),
      .exchange_go        (exchange_go),
      .exchange_client_id (exchange_client_id),
      .exchange_amount    (exchange_amount),
      .accumulated_orders (accumulated_orders),
      .max_to_trade       (max_to_trade),
      .cancelled_orders   (cancelled_orders),
      .order_ack          (order_ack),
      .order_reject       (order_reject),
      .locked             (locked)
   );

   typedef struct {
      string  tag;
      longint acc;
      longint max;
      longint cxl;
      bit     ack;
      bit     rej;
      bit     lck;
   } exp_t;

   exp_t   sb_q[$];
   int     n_vec = 0;
   int     n_err = 0;

   // Reference model state
   longint m_tab [NCLIENT];
   longint m_acc, m_max, m_cxl;
   bit     m_lck;

   task automatic model_clear();
      for (int i = 0; i < NCLIENT; i++) m_tab[i] = 0;
      m_acc = 0; m_max = 0; m_cxl = 0; m_lck = 0;
   endtask

   task automatic idle_inputs();
      cpu_go = 0; cpu_new_max = 0; cpu_client_id = '0; cpu_amount = '0;
      exchange_go = 0; exchange_client_id = '0; exchange_amount = '0;
   endtask

   // Drive one cycle of strobes (called on a falling edge), model it, push
   // the expectation, then pop and compare one cycle later.
   task automatic apply_vector(input string tag,
                               input bit cg, input bit nm, input int cid,
                               input longint camt,
                               input bit eg, input int eid, input longint eamt);
      exp_t   e, got;
      longint app;
      cpu_go = cg; cpu_new_max = nm;
      cpu_client_id = CLIENT_W'(cid); cpu_amount = AMT_W'(camt);
      exchange_go = eg; exchange_client_id = CLIENT_W'(eid);
      exchange_amount = CXL_W'(eamt);

      e.tag = tag; e.ack = 0; e.rej = 0;
      if (eg) begin
         app = (eamt < m_tab[eid]) ? eamt : m_tab[eid];
         m_tab[eid] -= app;
         m_acc      -= app;
         m_cxl      += app;
         if (m_cxl > 65535) m_cxl = 65535;
      end
      if (cg && nm) begin
         m_max = camt;
         if (m_lck && camt > m_acc) m_lck = 0;
      end else if (cg) begin
         if (!m_lck && (camt == 0 || m_acc + camt <= m_max)) begin
            m_tab[cid] += camt;
            m_acc      += camt;
            e.ack = 1;
         end else begin
            e.rej = 1;
            m_lck = 1;
         end
      end
      e.acc = m_acc; e.max = m_max; e.cxl = m_cxl; e.lck = m_lck;
      sb_q.push_back(e);

      @(negedge clk);
      idle_inputs();
      got = sb_q.pop_front();
      n_vec++;
      if (accumulated_orders !== AMT_W'(got.acc) || max_to_trade !== AMT_W'(got.max) ||
          cancelled_orders !== CXL_W'(got.cxl) || order_ack !== got.ack ||
          order_reject !== got.rej || locked !== got.lck) begin
         n_err++;
         $display("FAIL %s: got acc=%0d max=%0d cxl=%0d ack=%b rej=%b lck=%b, want acc=%0d max=%0d cxl=%0d ack=%b rej=%b lck=%b",
                  got.tag, accumulated_orders, max_to_trade, cancelled_orders,
                  order_ack, order_reject, locked,
                  got.acc, got.max, got.cxl, got.ack, got.rej, got.lck);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      HRESETn = 1'b0;
      model_clear();
      sb_q.delete();
      @(negedge clk);
      HRESETn = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      model_clear();
      HRESETn = 1'b0;
      #1;
      n_vec++;
      if (accumulated_orders !== '0 || max_to_trade !== '0 || cancelled_orders !== '0 ||
          order_ack !== 1'b0 || order_reject !== 1'b0 || locked !== 1'b0) begin
         n_err++;
         $display("FAIL reset_values: got acc=%0d max=%0d cxl=%0d ack=%b rej=%b lck=%b, want all 0",
                  accumulated_orders, max_to_trade, cancelled_orders, order_ack, order_reject, locked);
      end
      @(negedge clk);
      HRESETn = 1'b1;
      apply_vector("idle_after_reset", 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_limit_and_order();
      do_reset();
      apply_vector("limit_100",        1, 1, 0, 100, 0, 0, 0);
      apply_vector("order_c3_60_ack",  1, 0, 3, 60,  0, 0, 0);
      n_vec++;
      if (accumulated_orders !== 32'd60 || locked !== 1'b0) begin
         n_err++;
         $display("FAIL scen_ack_60: got acc=%0d lck=%b, want acc=60 lck=0", accumulated_orders, locked);
      end
      apply_vector("order_c4_50_rej",  1, 0, 4, 50,  0, 0, 0);
      n_vec++;
      if (accumulated_orders !== 32'd60 || locked !== 1'b1) begin
         n_err++;
         $display("FAIL scen_lock: got acc=%0d lck=%b, want acc=60 lck=1", accumulated_orders, locked);
      end
      apply_vector("zero_order_locked", 1, 0, 1, 0,   0, 0, 0);
      apply_vector("cancel_c3_80",     0, 0, 0, 0,   1, 3, 80);
      n_vec++;
      if (accumulated_orders !== 32'd0 || cancelled_orders !== 16'd60) begin
         n_err++;
         $display("FAIL scen_cancel: got acc=%0d cxl=%0d, want acc=0 cxl=60", accumulated_orders, cancelled_orders);
      end
      apply_vector("limit_200_unlock", 1, 1, 0, 200, 0, 0, 0);
      apply_vector("order_c1_200_ack", 1, 0, 1, 200, 0, 0, 0);
      n_vec++;
      if (order_ack !== 1'b1 || accumulated_orders !== 32'd200 || locked !== 1'b0) begin
         n_err++;
         $display("FAIL scen_full_limit: got ack=%b acc=%0d lck=%b, want ack=1 acc=200 lck=0",
                  order_ack, accumulated_orders, locked);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      apply_vector("limit_50",          1, 1, 0, 50, 0, 0, 0);
      apply_vector("order_c2_50",       1, 0, 2, 50, 0, 0, 0);
      apply_vector("cancel_and_order_c2", 1, 0, 2, 30, 1, 2, 30);
      n_vec++;
      if (order_ack !== 1'b1 || accumulated_orders !== 32'd50 || cancelled_orders !== 16'd30) begin
         n_err++;
         $display("FAIL same_cycle: got ack=%b acc=%0d cxl=%0d, want ack=1 acc=50 cxl=30",
                  order_ack, accumulated_orders, cancelled_orders);
      end
      // Draining client 2 exposes its entry: it must give back exactly 50.
      apply_vector("drain_c2",          0, 0, 0, 0,  1, 2, 100);
      // Cancel on one client, order on another, in the same cycle.
      apply_vector("order_c9_20",       1, 0, 9, 20, 0, 0, 0);
      apply_vector("split_cancel_order", 1, 0, 8, 30, 1, 9, 5);
      apply_vector("drain_c9",          0, 0, 0, 0,  1, 9, 100);
      apply_vector("drain_c8",          0, 0, 0, 0,  1, 8, 100);
   endtask

   task automatic test_low_limit();
      do_reset();
      apply_vector("limit_100",       1, 1, 0, 100, 0, 0, 0);
      apply_vector("order_c5_40",     1, 0, 5, 40,  0, 0, 0);
      apply_vector("limit_20_below",  1, 1, 0, 20,  0, 0, 0);
      apply_vector("zero_order_ack",  1, 0, 6, 0,   0, 0, 0);
      apply_vector("order_1_rej",     1, 0, 6, 1,   0, 0, 0);
      apply_vector("limit_eq_stays",  1, 1, 0, 40,  0, 0, 0);
      apply_vector("limit_41_unlock", 1, 1, 0, 41,  0, 0, 0);
      apply_vector("order_exact_fit", 1, 0, 6, 1,   0, 0, 0);
      apply_vector("order_over_by_1", 1, 0, 6, 1,   0, 0, 0);
      apply_vector("unlock_via_cancel", 1, 1, 0, 41, 1, 5, 1);
   endtask

   task automatic test_back_to_back();
      bit     cg, nm, eg;
      int     cid, eid;
      longint camt, eamt;
      do_reset();
      apply_vector("rand_limit", 1, 1, 0, 400, 0, 0, 0);
      for (int i = 0; i < 60; i++) begin
         cg   = ($urandom_range(0, 3) != 0);
         nm   = ($urandom_range(0, 5) == 0);
         cid  = $urandom_range(0, 7);
         camt = nm ? longint'($urandom_range(0, 600)) : longint'($urandom_range(0, 150));
         eg   = $urandom_range(0, 1);
         eid  = $urandom_range(0, 7);
         eamt = $urandom_range(0, 120);
         apply_vector("rand", cg, nm, cid, camt, eg, eid, eamt);
      end
   endtask

   task automatic test_saturation_and_reset();
      do_reset();
      apply_vector("limit_big",     1, 1, 0, 100000, 0, 0, 0);
      apply_vector("order_c7_65530", 1, 0, 7, 65530, 0, 0, 0);
      apply_vector("cancel_65530",  0, 0, 0, 0,     1, 7, 65530);
      apply_vector("order_c7_20",   1, 0, 7, 20,    0, 0, 0);
      apply_vector("cancel_10_sat", 0, 0, 0, 0,     1, 7, 10);
      n_vec++;
      if (cancelled_orders !== 16'hFFFF) begin
         n_err++;
         $display("FAIL saturate: got cxl=%h, want ffff", cancelled_orders);
      end
      // Reset lands between strobe setup and the clock edge.
      cpu_go = 1; cpu_new_max = 0; cpu_client_id = 5'd7; cpu_amount = 32'd5;
      exchange_go = 1; exchange_client_id = 5'd7; exchange_amount = 16'd3;
      #2;
      HRESETn = 1'b0;
      #1;
      n_vec++;
      if (accumulated_orders !== '0 || max_to_trade !== '0 || cancelled_orders !== '0 ||
          order_ack !== 1'b0 || order_reject !== 1'b0 || locked !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_strobe: got acc=%0d max=%0d cxl=%0d ack=%b rej=%b lck=%b, want all 0",
                  accumulated_orders, max_to_trade, cancelled_orders, order_ack, order_reject, locked);
      end
      @(negedge clk);
      idle_inputs();
      n_vec++;
      if (accumulated_orders !== '0 || cancelled_orders !== '0 || order_ack !== 1'b0 ||
          order_reject !== 1'b0) begin
         n_err++;
         $display("FAIL strobe_discarded: got acc=%0d cxl=%0d ack=%b rej=%b, want 0 0 0 0",
                  accumulated_orders, cancelled_orders, order_ack, order_reject);
      end
      HRESETn = 1'b1;
      model_clear();
      sb_q.delete();
      apply_vector("resume_limit_7", 1, 1, 0, 7, 0, 0, 0);
      apply_vector("resume_order",   1, 0, 7, 7, 0, 0, 0);
      apply_vector("resume_cancel_c7", 0, 0, 0, 0, 1, 7, 100);
   endtask

   initial begin
      test_reset();
      test_limit_and_order();
      test_same_cycle();
      test_low_limit();
      test_back_to_back();
      test_saturation_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/order_limit_tracker.md
ORDER_LIMIT_TRACKER -- requirements
Module: order_limit_tracker

Interface
REQ-001 Parameter CLIENT_W, default 5, client-id width; the table holds 2**CLIENT_W clients.
REQ-002 Parameter AMT_W, default 32, width of CPU amounts, limit and running totals.
REQ-003 Parameter CXL_W, default 16, width of exchange cancel amounts and the cancel counter.
REQ-004 Parameter LOCK_ON_HIT, default 1, where 1 locks on a rejected order and 0 means reject only.
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 HRESETn  in  1  asynchronous active-low reset.
REQ-007 cpu_go  in  1  CPU command strobe, valid for one cycle.
REQ-008 cpu_new_max  in  1  qualifies cpu_go: 1 is a limit write, 0 is an order.
REQ-009 cpu_client_id  in  CLIENT_W  client of the CPU order.
REQ-010 cpu_amount  in  AMT_W  order amount or new limit.
REQ-011 exchange_go  in  1  exchange cancel strobe.
REQ-012 exchange_client_id  in  CLIENT_W  client being cancelled.
REQ-013 exchange_amount  in  CXL_W  amount cancelled.
REQ-014 accumulated_orders  out  AMT_W  open total across all clients.
REQ-015 max_to_trade  out  AMT_W  current global limit.
REQ-016 cancelled_orders  out  CXL_W  saturating count of applied cancels.
REQ-017 order_ack  out  1  one-cycle pulse when an order is accepted.
REQ-018 order_reject  out  1  one-cycle pulse when an order is refused.
REQ-019 locked  out  1  high while the FSM is in LOCKED.

Function
REQ-020 All outputs SHALL be registered and SHALL reflect a strobe sampled at edge N at edge N+1, giving a latency of 1 cycle; the block accepts one strobe per interface per cycle with no back-pressure.
REQ-021 A limit write (cpu_go=1, cpu_new_max=1) SHALL load max_to_trade with cpu_amount and SHALL NOT pulse order_ack or order_reject.
REQ-022 A cancel SHALL compute applied = min(exchange_amount zero-extended, client_accum[exchange_client_id]).
REQ-023 A cancel SHALL subtract applied from that client entry and from accumulated_orders.
REQ-024 A cancel SHALL add applied to cancelled_orders, saturating at all-ones.
REQ-025 An order (cpu_go=1, cpu_new_max=0) in state RUN SHALL be accepted iff (accumulated_orders + cpu_amount), computed in AMT_W+1 bits, is <= max_to_trade.
REQ-026 An accepted order SHALL add cpu_amount to the client entry and to accumulated_orders and SHALL pulse order_ack.
REQ-027 A refused order SHALL change no total and SHALL pulse order_reject.
REQ-028 A zero-amount order SHALL be accepted with no total change.
REQ-029 FSM states are RUN and LOCKED.
REQ-030 RUN -> LOCKED SHALL occur on a rejected order when LOCK_ON_HIT=1.
REQ-031 LOCKED -> RUN SHALL occur on a limit write whose cpu_amount is strictly greater than the post-cancel accumulated_orders.
REQ-032 In LOCKED, every order SHALL be rejected, while cancels and limit writes are still processed.
REQ-033 On simultaneous cancel and CPU strobe in one cycle, the cancel SHALL apply first, and the order or limit check SHALL use the post-cancel totals; if both target the same client, both deltas SHALL combine into one entry write.
REQ-034 A limit write below the current accumulated_orders SHALL be legal, SHALL NOT alter totals, and SHALL cause subsequent nonzero orders to be rejected.

Reset
REQ-035 Asserting HRESETn low SHALL immediately clear all client entries, accumulated_orders, max_to_trade, cancelled_orders, order_ack, order_reject and locked to 0, and SHALL set the FSM to RUN.
REQ-036 Reset asserted mid-operation SHALL discard any strobe sampled in that cycle.
REQ-037 Operation SHALL resume on the first rising edge after HRESETn is released.

Structure
REQ-038 Package order_limit_pkg SHALL hold the FSM state enum and the default CLIENT_W, AMT_W and CXL_W constants.
REQ-039 Sub-module client_accum_table SHALL hold 2**CLIENT_W entries of AMT_W bits, with two combinational read ports (cancel, order) and one merged write port.
REQ-040 The top level SHALL hold the FSM, the limit/compare arithmetic and the output registers.

Verification
REQ-041 Scenario: limit write 100, then order client 3 amt 60 -> ack; accumulated_orders=60, locked=0.
REQ-042 Scenario: then order client 4 amt 50 -> reject; locked=1; accumulated_orders stays 60.
REQ-043 Scenario: then cancel client 3 amt 80 -> applied 60; accumulated_orders=0; cancelled_orders=60.
REQ-044 Scenario: then limit write 200 -> locked=0; order client 1 amt 200 -> ack.
REQ-045 Scenario: limit 50, accumulated_orders 50 held on client 2; same-cycle cancel client 2 amt 30 with order client 2 amt 30 -> ack; client 2 entry=50; cancelled_orders +30.
REQ-046 Scenario: cancelled_orders preloaded near 16'hFFFF, cancel applied 10 -> cancelled_orders=16'hFFFF; assert HRESETn low mid-strobe -> all outputs 0 on the same cycle.
